// File: rtl/usb_fs_endpoint_sender_multibuf.sv
// IN-endpoint packetiser: packs a byte stream into a ring of packet buffers and
// hands closed packets to the transaction layer while the next buffer keeps filling.
module usb_fs_endpoint_sender_multibuf #(
    parameter int MAX_PKT = 8,
    parameter int N_BUF   = 2,
    parameter int TIMEOUT = 0,
    parameter int ZLP_EN  = 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    output logic                       o_ready,
    input  logic                       i_valid,
    input  logic [7:0]                 i_data,
    input  logic                       i_flush,
    input  logic                       i_halt,
    output logic                       o_etStall,
    input  logic                       i_etReady,
    output logic                       o_etValid,
    output logic [8*MAX_PKT-1:0]       o_etData,
    output logic [$clog2(MAX_PKT):0]   o_etData_nBytes
);

    localparam int NBW = $clog2(MAX_PKT) + 1;
    localparam int PW  = $clog2(N_BUF);
    localparam int IW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [NBW-1:0] FULL_NB   = NBW'(MAX_PKT);
    localparam logic [IW-1:0]  IDLE_MAX  = IW'(TIMEOUT);
    localparam logic [IW-1:0]  IDLE_LAST = (TIMEOUT > 0) ? IW'(TIMEOUT - 1) : '0;

    logic [8*MAX_PKT-1:0] data [N_BUF];
    logic [NBW-1:0]       nbytes [N_BUF];
    logic [N_BUF-1:0]     closed;
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [IW-1:0]        idle_cnt;
    logic                 last_full;

    logic                 fill_open;
    logic                 accepted;
    logic                 et_accepted;
    logic                 do_close;
    logic                 idle_inc;
    logic [NBW-1:0]       fill_nb;
    logic [NBW-1:0]       fill_nb_next;

    always_comb begin
        fill_nb      = nbytes[wr_ptr];
        fill_open    = !closed[wr_ptr];
        accepted     = fill_open & !i_halt & i_valid;
        et_accepted  = i_etReady & closed[rd_ptr] & !i_halt;
        fill_nb_next = fill_nb + NBW'(accepted);
        do_close     = 1'b0;
        // Closing only ever targets an open fill buffer; halt does not block flush/timeout.
        if (fill_open) begin
            if (accepted && fill_nb_next == FULL_NB)
                do_close = 1'b1;
            if (i_flush && fill_nb_next != '0)
                do_close = 1'b1;
            if (TIMEOUT > 0 && !accepted && fill_nb != '0 && idle_cnt == IDLE_LAST)
                do_close = 1'b1;
            if (ZLP_EN != 0 && i_flush && !accepted && fill_nb == '0 && last_full)
                do_close = 1'b1;
        end
        idle_inc = fill_open && !accepted && fill_nb != '0 && idle_cnt != IDLE_MAX;
    end

    assign o_ready         = fill_open & !i_halt;
    assign o_etValid       = closed[rd_ptr] & !i_halt;
    assign o_etData        = data[rd_ptr];
    assign o_etData_nBytes = nbytes[rd_ptr];
    assign o_etStall       = i_halt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int unsigned b = 0; b < N_BUF; b++) begin
                data[b]   <= '0;
                nbytes[b] <= '0;
            end
            closed    <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            idle_cnt  <= '0;
            last_full <= 1'b0;
        end else begin
            if (accepted) begin
                for (int unsigned b = 0; b < MAX_PKT; b++)
                    if (fill_nb == NBW'(b))
                        data[wr_ptr][8*b +: 8] <= i_data;
                nbytes[wr_ptr] <= fill_nb_next;
            end
            if (do_close) begin
                closed[wr_ptr] <= 1'b1;
                wr_ptr         <= wr_ptr + PW'(1);
                last_full      <= (fill_nb_next == FULL_NB);
            end
            if (do_close || accepted)
                idle_cnt <= '0;
            else if (idle_inc)
                idle_cnt <= idle_cnt + IW'(1);
            // Fill and send buffers never coincide here, so both updates can land together.
            if (et_accepted) begin
                data[rd_ptr]   <= '0;
                nbytes[rd_ptr] <= '0;
                closed[rd_ptr] <= 1'b0;
                rd_ptr         <= rd_ptr + PW'(1);
            end
        end
    end

endmodule
